arith_unit_pipe: RTL and testbench
==================================

// Module: arith_unit_pipe
// PURPOSE
//   Parametrised two-stage pipelined arithmetic unit: transfer, add, subtract, negate on WIDTH-bit
//   two's-complement operands, optional internal accumulator as A operand/destination, status flags.
//   valid/ready on both sides; throughput 1 op/cycle. Sits between operand source and result consumer.
// PARAMETERS
//   WIDTH      3   operand/result width in bits (>=2)
// PORTS
//   clk        in   1      single clock, all state updates on posedge
//   rst        in   1      reset
//   in_valid   in   1      operation offered
//   in_ready   out  1      operation accepted when in_valid & in_ready
//   op         in   2      00 G=A (transfer), 01 G=A+B, 10 G=A+~B+1 (A-B), 11 G=~B+1 (-B)
//   src_acc    in   1      1: accumulator replaces A as X operand (ignored for op 11)
//   wr_acc     in   1      1: result also written to accumulator
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   out_valid  out  1      result available
//   out_ready  in   1      result consumed when out_valid & out_ready
//   g          out  WIDTH  result
//   carry      out  1      carry out of MSB (sub: 1 = no borrow)
//   ovf        out  1      signed overflow = carry into MSB ^ carry out of MSB
//   zero       out  1      g == 0
//   neg        out  1      g[WIDTH-1]
//   acc        out  WIDTH  current accumulator value
// BEHAVIOUR
//   - Reset: one clock; reset is synchronous and active-high. On rst: s1/s2 valid=0, acc=0,
//     g/carry/ovf/zero/neg=0, out_valid=0. rst overrides any handshake same cycle; in-flight ops dropped.
//   - Stage 1 (accept): registers op, src_acc, wr_acc, a, Y = {0 | B | ~B | ~B} by op, cin = op[1].
//   - Stage 2 (execute): X = (op==11) ? 0 : (src_acc ? acc : a); {carry,g} = X + Y + cin;
//     flags registered with g. If wr_acc, acc <= g on the same edge s2 loads.
//   - acc read at stage-2 load: back-to-back acc ops see previous result; no stall, no forwarding.
//   - Advance: s2_load = s1_valid & (~out_valid | out_ready); s1_load = in_valid & in_ready;
//     in_ready = ~s1_valid | s2_load (combinational, no dependence on in_valid).
//   - out_valid clears when consumed with no s2_load; g/flags hold while out_valid & ~out_ready.
//   - Latency: op accepted at edge t appears on g with out_valid after edge t+2 (out_ready high).
//   - Full: both stages valid and out_ready low -> in_ready=0; nothing lost or duplicated.
//   - Simultaneous consume + load: out_valid stays 1, new result replaces old same edge.
//   - Wrap-around: result modulo 2^WIDTH; acc wraps silently, carry/ovf report it.
//   - op 00: carry=0, ovf=0. op 11 with b=100..0: g=b, ovf=1.
// STRUCTURE
//   - arith_pkg.vh: op encoding localparams (OP_XFER, OP_ADD, OP_SUB, OP_NEG).
//   - Sub-module ripple_adder_n #(WIDTH): chain of full_adder cells, outputs sum, carry out,
//     carry into MSB (for ovf). Operand muxes and pipeline control stay in top level.
// TESTING (WIDTH=3 unless noted)
//   1 a=101 b=101, ops 00/01/10/11, out_ready=1 -> g=101 neg=1; g=010 carry=1 ovf=1;
//     g=000 carry=1 zero=1; g=011 carry=0.
//   2 acc=0, 8x op01 src_acc=1 wr_acc=1 b=001 back-to-back -> g=001..111 then 000 carry=1
//     zero=1 on 8th; acc=000 at end; one result per cycle after 2-cycle latency.
//   3 Stream 5 ops, out_ready=0 for 4 cycles -> in_ready=0 once 2 held; all 5 results in order.
//   4 op11 b=100 -> g=100 ovf=1 neg=1; op10 a=011 b=100 -> g=111 ovf=1.
//   5 rst=1 with both stages valid, acc=110 -> next edge out_valid=0, in_ready=1, acc=000, g=000.
//   6 WIDTH=8: a=0x7F b=0x01 op01 -> g=0x80 ovf=1 neg=1 carry=0; a=0x00 b=0x01 op10 -> g=0xFF carry=0.

Source files
------------

// File: rtl/arith_unit_pipe_pkg.sv
// arith_unit_pipe_pkg: op encodings shared by the arithmetic pipeline
package arith_unit_pipe_pkg;
  localparam logic [1:0] OP_XFER = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_NEG  = 2'b11;
endpackage

// File: rtl/ripple_adder_n.sv
// ripple_adder_n: ripple-carry adder built from a chain of full-adder cells
module ripple_adder_n #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             cmsb
);
  logic [WIDTH:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : full_adder
    assign sum[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end
  assign cout = c[WIDTH];
  assign cmsb = c[WIDTH-1];
endmodule

// File: rtl/arith_unit_pipe.sv
// arith_unit_pipe: two-stage valid/ready pipelined add/sub/neg/transfer unit with accumulator
module arith_unit_pipe
  import arith_unit_pipe_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             src_acc,
  input  logic             wr_acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] g,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic [WIDTH-1:0] acc
);
  logic             s1_valid, s1_src, s1_wr, s1_cin, s1_load, s2_load, cout, cmsb;
  logic [1:0]       s1_op;
  logic [WIDTH-1:0] s1_a, s1_y, x, sum;
  assign s2_load  = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | s2_load;
  assign s1_load  = in_valid & in_ready;
  assign x        = (s1_op == OP_NEG) ? '0 : (s1_src ? acc : s1_a);
  ripple_adder_n #(.WIDTH(WIDTH)) u_add (
    .x    (x),
    .y    (s1_y),
    .cin  (s1_cin),
    .sum  (sum),
    .cout (cout),
    .cmsb (cmsb)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= s1_load | (s1_valid & ~s2_load);
      if (s1_load) begin
        s1_op  <= op;
        s1_src <= src_acc;
        s1_wr  <= wr_acc;
        s1_a   <= a;
        s1_y   <= (op == OP_XFER) ? '0 : ((op == OP_ADD) ? b : ~b);
        s1_cin <= (op == OP_SUB) || (op == OP_NEG);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      g         <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      acc       <= '0;
    end else begin
      out_valid <= s2_load | (out_valid & ~out_ready);
      if (s2_load) begin
        g     <= sum;
        carry <= cout;
        ovf   <= cout ^ cmsb;
        zero  <= (sum == '0);
        neg   <= sum[WIDTH-1];
        if (s1_wr) acc <= sum;
      end
    end
  end
endmodule

// File: tb/tb_arith_unit_pipe.sv
// tb_arith_unit_pipe: directed self-checking bench for arith_unit_pipe
module tb_arith_unit_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst, in_valid, in_ready, src_acc, wr_acc, out_valid, out_ready;
  logic       carry, ovf, zero, neg;
  logic [1:0] op;
  logic [2:0] a, b, g, acc;
  logic       in_valid8, in_ready8, src_acc8, wr_acc8, out_valid8, out_ready8;
  logic       carry8, ovf8, zero8, neg8;
  logic [1:0] op8;
  logic [7:0] a8, b8, g8, acc8;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic [1:0] op;
    logic       src;
    logic       wr;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] g;
    logic [3:0] f;
  } vec_t;
  vec_t vq[$];
  arith_unit_pipe #(.WIDTH(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src_acc(src_acc), .wr_acc(wr_acc), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .g(g), .carry(carry), .ovf(ovf), .zero(zero),
    .neg(neg), .acc(acc)
  );
  arith_unit_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .src_acc(src_acc8), .wr_acc(wr_acc8), .a(a8), .b(b8), .out_valid(out_valid8),
    .out_ready(out_ready8), .g(g8), .carry(carry8), .ovf(ovf8), .zero(zero8),
    .neg(neg8), .acc(acc8)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [1:0] o, input logic s, input logic w, input logic [2:0] av,
                      input logic [2:0] bv, input logic [2:0] gv, input logic [3:0] fv);
    vec_t v;
    v.op = o; v.src = s; v.wr = w; v.a = av; v.b = bv; v.g = gv; v.f = fv;
    vq.push_back(v);
  endtask
  task automatic run(input int hold_from, input int hold_len);
    int tx = 0;
    int rx = 0;
    int n  = vq.size();
    for (int cyc = 0; cyc < 200 && rx < n; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= hold_from && cyc < hold_from + hold_len);
      in_valid  = (tx < n);
      if (tx < n) begin
        op = vq[tx].op; src_acc = vq[tx].src; wr_acc = vq[tx].wr; a = vq[tx].a; b = vq[tx].b;
      end
      #1;
      if (hold_len == 4 && cyc < 5) chk("in_ready_stall", in_ready, (cyc == 2 || cyc == 3) ? 0 : 1);
      if (out_valid && out_ready) begin
        chk("g", g, vq[rx].g);
        chk("flags", {carry, ovf, zero, neg}, vq[rx].f);
        if (hold_len == 0) chk("latency", cyc, rx + 2);
        rx++;
      end
      if (in_valid && in_ready) tx++;
    end
    chk("drained", rx, n);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("no_dup", out_valid, 0);
    vq.delete();
  endtask
  initial begin
    rst = 1'b1; in_valid = 0; op = 0; src_acc = 0; wr_acc = 0; a = 0; b = 0; out_ready = 1;
    in_valid8 = 0; op8 = 0; src_acc8 = 0; wr_acc8 = 0; a8 = 0; b8 = 0; out_ready8 = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_g", g, 0);
    chk("rst_flags", {carry, ovf, zero, neg}, 0);
    chk("rst_acc", acc, 0);
    push(2'b00, 0, 0, 3'b101, 3'b101, 3'b101, 4'b0001);
    push(2'b01, 0, 0, 3'b101, 3'b101, 3'b010, 4'b1100);
    push(2'b10, 0, 0, 3'b101, 3'b101, 3'b000, 4'b1010);
    push(2'b11, 0, 0, 3'b101, 3'b101, 3'b011, 4'b0000);
    run(0, 0);
    push(2'b01, 1, 1, 3'b000, 3'b001, 3'b001, 4'b0000);
    push(2'b01, 1, 1, 3'b000, 3'b001, 3'b010, 4'b0000);
    push(2'b01, 1, 1, 3'b000, 3'b001, 3'b011, 4'b0000);
    push(2'b01, 1, 1, 3'b000, 3'b001, 3'b100, 4'b0101);
    push(2'b01, 1, 1, 3'b000, 3'b001, 3'b101, 4'b0001);
    push(2'b01, 1, 1, 3'b000, 3'b001, 3'b110, 4'b0001);
    push(2'b01, 1, 1, 3'b000, 3'b001, 3'b111, 4'b0001);
    push(2'b01, 1, 1, 3'b000, 3'b001, 3'b000, 4'b1010);
    run(0, 0);
    chk("acc_wrap", acc, 0);
    push(2'b00, 0, 0, 3'b000, 3'b000, 3'b000, 4'b0010);
    push(2'b00, 0, 0, 3'b001, 3'b000, 3'b001, 4'b0000);
    push(2'b00, 0, 0, 3'b010, 3'b000, 3'b010, 4'b0000);
    push(2'b00, 0, 0, 3'b011, 3'b000, 3'b011, 4'b0000);
    push(2'b00, 0, 0, 3'b100, 3'b000, 3'b100, 4'b0001);
    run(0, 4);
    push(2'b00, 0, 1, 3'b010, 3'b000, 3'b010, 4'b0000);
    push(2'b11, 1, 0, 3'b000, 3'b100, 3'b100, 4'b0101);
    push(2'b10, 0, 0, 3'b011, 3'b100, 3'b111, 4'b0101);
    push(2'b01, 1, 0, 3'b000, 3'b001, 3'b011, 4'b0000);
    run(0, 0);
    chk("acc_kept", acc, 3'b010);
    @(negedge clk);
    in_valid = 1; op = 2'b00; src_acc = 0; wr_acc = 1; a = 3'b110; b = 0; out_ready = 1;
    @(negedge clk);
    in_valid = 0; wr_acc = 0;
    repeat (3) @(negedge clk);
    chk("acc_load", acc, 3'b110);
    out_ready = 0; in_valid = 1; op = 2'b01; a = 3'b001; b = 3'b001;
    repeat (3) @(negedge clk);
    #1;
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    rst = 1;
    @(negedge clk);
    rst = 0; in_valid = 0;
    #1;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_in_ready", in_ready, 1);
    chk("rst2_acc", acc, 0);
    chk("rst2_g", g, 0);
    out_ready = 1;
    @(negedge clk);
    #1;
    chk("rst2_dropped", out_valid, 0);
    @(negedge clk);
    in_valid8 = 1; op8 = 2'b01; a8 = 8'h7F; b8 = 8'h01;
    @(negedge clk);
    op8 = 2'b10; a8 = 8'h00; b8 = 8'h01;
    @(negedge clk);
    in_valid8 = 0;
    #1;
    chk("w8_add_valid", out_valid8, 1);
    chk("w8_add_g", g8, 8'h80);
    chk("w8_add_flags", {carry8, ovf8, zero8, neg8}, 4'b0101);
    @(negedge clk);
    #1;
    chk("w8_sub_g", g8, 8'hFF);
    chk("w8_sub_flags", {carry8, ovf8, zero8, neg8}, 4'b0001);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
